// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM request arbiter.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_A,
        SEL_B,
        SEL_REF
    } client_sel_e;

    localparam int DEF_REFRESH_PERIOD = 390;
    localparam int DEF_STROBE_LEN     = 2;
    localparam int DEF_OP_CYCLES      = 12;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Client ports plus SDRAM controller command bus seen by the arbiter.
// The master view belongs to the arbiter; the slave view is the
// environment (clients and controller).
interface sdram_arb_if;

    logic        sdReady;
    logic        sdRefresh;
    logic        sdWrite;
    logic        sdRead;
    logic [23:0] sdA;
    logic [15:0] sdD;
    logic [15:0] sdQ;

    logic        aReq;
    logic        aWe;
    logic [23:0] aA;
    logic [15:0] aD;
    logic [15:0] aQ;
    logic        aAck;

    logic        bReq;
    logic [23:0] bA;
    logic [15:0] bQ;
    logic        bAck;

    modport master (
        input  sdReady, sdQ,
        input  aReq, aWe, aA, aD,
        input  bReq, bA,
        output sdRefresh, sdWrite, sdRead, sdA, sdD,
        output aQ, aAck, bQ, bAck
    );

    modport slave (
        output sdReady, sdQ,
        output aReq, aWe, aA, aD,
        output bReq, bA,
        input  sdRefresh, sdWrite, sdRead, sdA, sdD,
        input  aQ, aAck, bQ, bAck
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator: a down-counter that raises a sticky
// pending flag at each expiry until the arbiter grants a refresh slot.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic pending
);

    localparam int CW = cntWidth(REFRESH_PERIOD);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_PERIOD - 1);

    logic [CW-1:0] count_q, count_d;
    logic          pending_q, pending_d;

    // Next-state: an expiry in the same cycle as a clear wins, so a fresh request is never lost.
    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        if (clear) begin
            pending_d = 1'b0;
        end
        if (enable) begin
            if (count_q == '0) begin
                count_d   = RELOAD;
                pending_d = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= RELOAD;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/sdram_arb.sv
// Arbiter and command sequencer in front of the SDRAM controller: picks
// refresh, CPU (A) or video (B), drives one falling-edge command strobe per
// fixed-length slot and returns read data with a one-cycle ack.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter int STROBE_LEN     = DEF_STROBE_LEN,
    parameter int OP_CYCLES      = DEF_OP_CYCLES
) (
    input logic         clock,
    input logic         reset,
    sdram_arb_if.master bus
);

    localparam int CNT_W = cntWidth((OP_CYCLES > STROBE_LEN) ? OP_CYCLES : STROBE_LEN);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] OP_LAST     = CNT_W'(OP_CYCLES - 1);

    arb_state_e  state_q;
    client_sel_e sel_q;
    client_sel_e winner_d;
    logic [CNT_W-1:0] cnt_q;
    logic        we_q;
    logic        lastB_q;
    logic        sdRefresh_q, sdWrite_q, sdRead_q;
    logic [23:0] sdA_q;
    logic [15:0] sdD_q;
    logic [15:0] aQ_q, bQ_q;
    logic        aAck_q, bAck_q;
    logic        refPending;
    logic        refClear;
    logic        timerEnable;

    assign timerEnable = (state_q != ST_INIT);
    assign refClear    = (state_q == ST_IDLE) && bus.sdReady && (winner_d == SEL_REF);

    sdram_refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (timerEnable),
        .clear  (refClear),
        .pending(refPending)
    );

    // Grant decision: refresh first, then whichever client was not served last.
    always_comb begin
        winner_d = SEL_NONE;
        if (refPending) begin
            winner_d = SEL_REF;
        end else if (lastB_q) begin
            if (bus.aReq)      winner_d = SEL_A;
            else if (bus.bReq) winner_d = SEL_B;
        end else begin
            if (bus.bReq)      winner_d = SEL_B;
            else if (bus.aReq) winner_d = SEL_A;
        end
    end

    // Slot sequencer with registered strobes, bus, read data and acks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            sel_q       <= SEL_NONE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            lastB_q     <= 1'b1;
            sdRefresh_q <= 1'b0;
            sdWrite_q   <= 1'b0;
            sdRead_q    <= 1'b0;
            sdA_q       <= '0;
            sdD_q       <= '0;
            aQ_q        <= '0;
            bQ_q        <= '0;
            aAck_q      <= 1'b0;
            bAck_q      <= 1'b0;
        end else begin
            aAck_q <= 1'b0;
            bAck_q <= 1'b0;
            if (state_q != ST_INIT && !bus.sdReady) begin
                state_q     <= ST_INIT;
                sel_q       <= SEL_NONE;
                cnt_q       <= '0;
                sdRefresh_q <= 1'b0;
                sdWrite_q   <= 1'b0;
                sdRead_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        if (bus.sdReady) state_q <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (winner_d != SEL_NONE) begin
                            sel_q   <= winner_d;
                            cnt_q   <= '0;
                            state_q <= ST_STROBE;
                            case (winner_d)
                                SEL_REF: sdRefresh_q <= 1'b1;
                                SEL_A: begin
                                    sdA_q     <= bus.aA;
                                    sdD_q     <= bus.aD;
                                    we_q      <= bus.aWe;
                                    sdWrite_q <= bus.aWe;
                                    sdRead_q  <= !bus.aWe;
                                end
                                SEL_B: begin
                                    sdA_q    <= bus.bA;
                                    we_q     <= 1'b0;
                                    sdRead_q <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_STROBE: begin
                        if (cnt_q == STROBE_LAST) begin
                            sdRefresh_q <= 1'b0;
                            sdWrite_q   <= 1'b0;
                            sdRead_q    <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= ST_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q == OP_LAST) begin
                            if (sel_q == SEL_A && !we_q) aQ_q <= bus.sdQ;
                            if (sel_q == SEL_B)          bQ_q <= bus.sdQ;
                            aAck_q  <= (sel_q == SEL_A);
                            bAck_q  <= (sel_q == SEL_B);
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (sel_q == SEL_A) lastB_q <= 1'b0;
                        if (sel_q == SEL_B) lastB_q <= 1'b1;
                        sel_q   <= SEL_NONE;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_INIT;
                endcase
            end
        end
    end

    assign bus.sdRefresh = sdRefresh_q;
    assign bus.sdWrite   = sdWrite_q;
    assign bus.sdRead    = sdRead_q;
    assign bus.sdA       = sdA_q;
    assign bus.sdD       = sdD_q;
    assign bus.aQ        = aQ_q;
    assign bus.aAck      = aAck_q;
    assign bus.bQ        = bQ_q;
    assign bus.bAck      = bAck_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed testbench for sdram_arb with default parameters. Cycle k of a
// slot is the cycle after the k-th rising edge following the IDLE cycle in
// which the request was presented; outputs are sampled on falling edges.
module tb_sdram_arb;
    import sdram_arb_pkg::*;

    logic clock;
    logic reset;
    int   testsRun;
    int   testsFailed;
    int   cyc;

    sdram_arb_if bus();

    sdram_arb dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic applyStimulus(input logic aReqV, input logic aWeV, input logic [23:0] aAV,
                                 input logic [15:0] aDV, input logic bReqV, input logic [23:0] bAV);
        bus.aReq = aReqV;
        bus.aWe  = aWeV;
        bus.aA   = aAV;
        bus.aD   = aDV;
        bus.bReq = bReqV;
        bus.bA   = bAV;
    endtask

    // Called on the falling edge of an IDLE cycle with the request already presented;
    // follows the slot to its ack cycle (k = 15) and optionally withdraws all requests there.
    task automatic runSlot(input string tag, input client_sel_e sel, input logic isWrite,
                           input logic [23:0] expA, input logic [15:0] expD,
                           input logic [15:0] modelQ, input logic dropReq);
        logic [15:0] rdProf, wrProf, rfProf, aAckProf, bAckProf;
        logic [15:0] expStrobe, expAck;
        int addrErr, dataErr;
        logic [15:0] gotQ;
        rdProf = '0; wrProf = '0; rfProf = '0; aAckProf = '0; bAckProf = '0;
        addrErr = 0; dataErr = 0; gotQ = '0;
        expStrobe = 16'h0006;
        expAck    = 16'h8000;
        bus.sdQ = modelQ;
        for (int k = 1; k <= 15; k++) begin
            tick();
            rdProf[k]   = bus.sdRead;
            wrProf[k]   = bus.sdWrite;
            rfProf[k]   = bus.sdRefresh;
            aAckProf[k] = bus.aAck;
            bAckProf[k] = bus.bAck;
            if (bus.sdA !== expA) addrErr++;
            if (bus.sdD !== expD) dataErr++;
            if (k == 15) begin
                gotQ = (sel == SEL_A) ? bus.aQ : bus.bQ;
                if (dropReq) begin
                    bus.aReq = 1'b0;
                    bus.bReq = 1'b0;
                end
            end
        end
        checkOutput({tag, "_sdRead"},    32'(rdProf), 32'((sel == SEL_B || (sel == SEL_A && !isWrite)) ? expStrobe : 16'h0));
        checkOutput({tag, "_sdWrite"},   32'(wrProf), 32'((sel == SEL_A && isWrite) ? expStrobe : 16'h0));
        checkOutput({tag, "_sdRefresh"}, 32'(rfProf), 32'((sel == SEL_REF) ? expStrobe : 16'h0));
        checkOutput({tag, "_aAck"},      32'(aAckProf), 32'((sel == SEL_A) ? expAck : 16'h0));
        checkOutput({tag, "_bAck"},      32'(bAckProf), 32'((sel == SEL_B) ? expAck : 16'h0));
        checkOutput({tag, "_sdA_stable"}, addrErr, 0);
        if (isWrite) checkOutput({tag, "_sdD_stable"}, dataErr, 0);
        else         checkOutput({tag, "_readQ"}, 32'(gotQ), 32'(modelQ));
    endtask

    // Main directed sequence.
    initial begin
        int strobeSeen, ackSeen, w, rf1, rf2, rf3, t0, lat, aCnt, bCnt;
        logic prevRf;
        testsRun = 0;
        testsFailed = 0;
        cyc = 0;
        reset = 1'b0;
        bus.sdReady = 1'b0;
        bus.sdQ = '0;
        applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);

        // Reset release with controller not ready.
        repeat (3) tick();
        reset = 1'b1;
        strobeSeen = 0; ackSeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            strobeSeen += int'(bus.sdRead) + int'(bus.sdWrite) + int'(bus.sdRefresh);
            ackSeen    += int'(bus.aAck) + int'(bus.bAck);
        end
        checkOutput("reset_strobes", strobeSeen, 0);
        checkOutput("reset_acks", ackSeen, 0);
        checkOutput("reset_aQ", 32'(bus.aQ), 32'h0);
        checkOutput("reset_bQ", 32'(bus.bQ), 32'h0);
        checkOutput("reset_sdA", 32'(bus.sdA), 32'h0);
        checkOutput("reset_sdD", 32'(bus.sdD), 32'h0);
        checkOutput("reset_state_init", 32'(dut.state_q), 32'(ST_INIT));

        // Controller ready: IDLE one cycle later (cycle c0).
        bus.sdReady = 1'b1;
        tick();
        cyc = 0;
        checkOutput("ready_to_idle", 32'(dut.state_q), 32'(ST_IDLE));

        // CPU write, slot c0..c15.
        applyStimulus(1'b1, 1'b1, 24'h012345, 16'hBEEF, 1'b0, 24'h0);
        runSlot("cpu_wr", SEL_A, 1'b1, 24'h012345, 16'hBEEF, 16'h0, 1'b1);
        tick();

        // Video read, slot c16..c31.
        applyStimulus(1'b0, 1'b0, 24'h0, 16'hBEEF, 1'b1, 24'h000100);
        runSlot("vid_rd", SEL_B, 1'b0, 24'h000100, 16'hBEEF, 16'h5A5A, 1'b1);
        tick();

        // Both clients held: A, B, A, B, slots c32..c95.
        applyStimulus(1'b1, 1'b0, 24'h000200, 16'h1111, 1'b1, 24'h000300);
        for (int i = 0; i < 4; i++) begin
            runSlot((i % 2 == 0) ? "alt_a" : "alt_b", (i % 2 == 0) ? SEL_A : SEL_B, 1'b0,
                    (i % 2 == 0) ? 24'h000200 : 24'h000300, 16'h1111, 16'(16'h1000 + i), (i == 3));
            if (i < 3) tick();
        end

        // Idle clients: first refresh strobe at c391, then every 390 cycles.
        t0 = cyc;
        while (!bus.sdRefresh && (cyc - t0) < 1000) tick();
        rf1 = cyc;
        checkOutput("ref_first_delay", rf1 - t0, 296);
        w = 0; ackSeen = 0;
        while (bus.sdRefresh && w < 10) begin
            w++;
            tick();
        end
        checkOutput("ref_strobe_width", w, 2);
        while (!bus.sdRefresh && (cyc - rf1) < 1000) begin
            ackSeen += int'(bus.aAck) + int'(bus.bAck);
            tick();
        end
        rf2 = cyc;
        checkOutput("ref_period", rf2 - rf1, 390);
        checkOutput("ref_no_ack", ackSeen, 0);

        // Both clients saturating: next refresh still squeezes in within 32 cycles of expiry.
        applyStimulus(1'b1, 1'b0, 24'h000400, 16'h0, 1'b1, 24'h000500);
        bus.sdQ = 16'h7777;
        aCnt = 0; bCnt = 0;
        prevRf = 1'b1;
        begin : satLoop
            while ((cyc - rf2) < 1000) begin
                tick();
                aCnt += int'(bus.aAck);
                bCnt += int'(bus.bAck);
                if (bus.sdRefresh && !prevRf) disable satLoop;
                prevRf = bus.sdRefresh;
            end
        end
        rf3 = cyc;
        lat = rf3 - rf2 - 389;
        checkOutput("sat_ref_latency_ok", 32'(lat >= 1 && lat <= 32), 32'h1);
        checkOutput("sat_ack_balance", aCnt, bCnt);
        checkOutput("sat_ack_total", aCnt + bCnt, 24);
        checkOutput("sat_aQ", 32'(bus.aQ), 32'h7777);

        // Drop sdReady in the WAIT phase of a CPU read.
        bus.bReq = 1'b0;
        bus.sdQ = 16'h0F0F;
        t0 = cyc;
        while (!bus.sdRead && (cyc - t0) < 100) tick();
        checkOutput("drop_read_start", cyc - t0, 16);
        repeat (4) tick();
        bus.sdReady = 1'b0;
        strobeSeen = 0; ackSeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            strobeSeen += int'(bus.sdRead) + int'(bus.sdWrite) + int'(bus.sdRefresh);
            ackSeen    += int'(bus.aAck) + int'(bus.bAck);
        end
        checkOutput("drop_strobes", strobeSeen, 0);
        checkOutput("drop_no_ack", ackSeen, 0);
        checkOutput("drop_aQ_hold", 32'(bus.aQ), 32'h7777);
        checkOutput("drop_state_init", 32'(dut.state_q), 32'(ST_INIT));

        // Restore: the held CPU read reissues and completes.
        bus.sdReady = 1'b1;
        tick();
        checkOutput("restore_idle", 32'(dut.state_q), 32'(ST_IDLE));
        runSlot("reissue_rd", SEL_A, 1'b0, 24'h000400, 16'h0, 16'hC3C3, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Request arbiter and sequencer sitting directly upstream of the SDRAM controller. It multiplexes a read/write CPU port and a read-only video port onto the controller's single command interface. It generates periodic refresh requests and drives the controller's falling-edge-triggered `read`/`write`/`refresh` strobes. It returns read data and a one-cycle acknowledge to the winning client.

## Interface
- `REFRESH_PERIOD`, default 390: clock cycles between refresh requests.
- `STROBE_LEN`, default 2: cycles a strobe is held high before its falling edge.
- `OP_CYCLES`, default 12: cycles from strobe falling edge to read-data sample and ack; must exceed controller decode latency plus 8.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `sdReady`  in  1  controller ready (initialisation complete).
- `sdRefresh` / `sdWrite` / `sdRead`  out  1 each  controller command strobes; the command fires on the falling edge.
- `sdA`  out  24  controller address.
- `sdD`  out  16  controller write data.
- `sdQ`  in  16  controller read data.
- `aReq`  in  1  CPU request, level; held until `aAck`.
- `aWe`  in  1  CPU write (1) / read (0).
- `aA`  in  24  CPU address.
- `aD`  in  16  CPU write data.
- `aQ`  out  16  CPU read data.
- `aAck`  out  1  one-cycle done pulse.
- `bReq`  in  1  video read request, level; held until `bAck`.
- `bA`  in  24  video address.
- `bQ`  out  16  video read data.
- `bAck`  out  1  one-cycle done pulse.

## Operation
- FSM states: INIT, IDLE, STROBE, WAIT, DONE.
- INIT: all strobes low. Moves to IDLE on the first cycle `sdReady`=1.
- IDLE: grant decision, priority order:
  - refresh pending;
  - then the A/B client that was not served last, if it is requesting;
  - then the other client.
- On grant in IDLE:
  - latch the winner's address, data and direction into `sdA`/`sdD`;
  - raise exactly one strobe;
  - go to STROBE. `sdA`/`sdD` stay frozen until DONE.
- STROBE: counter runs for STROBE_LEN cycles, then the strobe drops (the falling edge launches the command). Go to WAIT.
- WAIT: OP_CYCLES cycles. On the last cycle, a read captures `sdQ` into `aQ` or `bQ`.
- DONE: one cycle. Pulse `aAck` or `bAck` (no ack for refresh), update the last-served flag, return to IDLE.
- A refresh slot clears the refresh-pending flag on grant.
- Refresh timer:
  - down-counter loaded with REFRESH_PERIOD-1;
  - at 0 it sets refresh-pending and reloads;
  - expiry while already pending leaves pending set (no queueing).
  - The timer runs in every state except INIT.
- The video port is never written. `aWe` is sampled only at grant.
- `aQ`/`bQ` hold their last read value until the next read for that port.
- `sdReady` falling in any state other than INIT:
  - immediately drop all strobes and go to INIT;
  - the in-flight op is abandoned with no ack;
  - the client's still-held request is reissued after `sdReady` returns.
- Reset values: state INIT, all strobes 0, `aAck`/`bAck` 0, `aQ`/`bQ`/`sdA`/`sdD` 0, refresh counter REFRESH_PERIOD-1, pending 0, last-served = B (so A wins the first tie).

## Timing
- Slot length is fixed: 1 (IDLE grant) + STROBE_LEN + OP_CYCLES + 1 (DONE) cycles. This is 16 with the defaults.
- A grant is possible on the cycle after DONE. Back-to-back slots are 16 cycles apart.
- The strobe rises on the cycle after the IDLE grant edge and falls exactly STROBE_LEN cycles later.
- Read data is valid in `aQ`/`bQ` in the same cycle as the ack pulse.
- A request rising while a slot is busy is served no earlier than the next IDLE. It waits at most 2 slots: one refresh plus one other-client slot.
- Simultaneous `aReq`, `bReq` and pending refresh: refresh first, then the clients alternate.
- Counter widths: $clog2 of each parameter. No wrap past the terminal count.

## Structure
- Package `sdram_arb_pkg` holds:
  - the FSM state enumeration;
  - client-select encoding (NONE, A, B, REF);
  - default parameter constants.
- Sub-module `sdram_refresh_timer` holds the down-counter and pending flag. Inputs: `clock`, `reset`, `enable`, `clear`. Output: `pending`.
- Everything else lives in one FSM in `sdram_arb`.

## Test plan
- Reset release with `sdReady`=0 for 20 cycles → all outputs 0, no strobe. `sdReady`=1 → IDLE one cycle later.
- `aReq`,`aWe`=1, `aA`=0x012345, `aD`=0xBEEF → `sdWrite` high for cycles 1–2, falls at 3, `sdA`/`sdD` stable until `aAck` at cycle 15; `sdRead` stays 0.
- `bReq`, `bA`=0x000100, model returns `sdQ`=0x5A5A → `bQ`=0x5A5A with `bAck` at cycle 15.
- `aReq` and `bReq` both held continuously → acks alternate A, B, A, B, one every 16 cycles.
- Both clients idle → `sdRefresh` pulse every REFRESH_PERIOD cycles. With both clients saturating, a refresh slot appears within 32 cycles of each timer expiry.
- Drop `sdReady` during WAIT of a CPU read → strobes 0 and no `aAck`. Restore `sdReady` → the read reissues and acks.
